// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and a small decode helper used by the top level and the shift levels.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Left shifts are executed as right shifts on bit-reversed data.
  function automatic logic op_is_sll(input logic [1:0] op);
    return (op == OP_SLL);
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One combinational shift level: shifts right by AMT when en is set.
// Left shifts arrive here already bit-reversed, so only right-going
// movement is needed; the fill bits depend on the operation.
module shift_level
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  // Select the fill for the vacated upper bits and apply the shift.
  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_ROR:  result = {data[AMT-1:0], data[WIDTH-1:AMT]};
        OP_SRA:  result = {{AMT{sign}}, data[WIDTH-1:AMT]};
        OP_SRL:  result = {{AMT{1'b0}}, data[WIDTH-1:AMT]};
        OP_SLL:  result = {{AMT{1'b0}}, data[WIDTH-1:AMT]};
        default: result = {{AMT{1'b0}}, data[WIDTH-1:AMT]};
      endcase
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter (SRL/SRA/SLL/ROR) built from log2(WIDTH)
// shift levels. With REG_LVL=1 every level is followed by a register;
// with REG_LVL=0 the levels are chained and only the output is registered.
// Stages form a valid/enable chain so empty stages fill under stall.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHIFTW  = 5,
  parameter int REG_LVL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHIFTW-1:0] in_shamt,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_zero
);

  localparam int NSTG = (REG_LVL != 0) ? SHIFTW : 1;

  // Inputs and outputs of every shift level.
  logic [WIDTH-1:0]  lin_data_s  [SHIFTW];
  logic [WIDTH-1:0]  lout_data_s [SHIFTW];
  logic [SHIFTW-1:0] lin_shamt_s [SHIFTW];
  logic [1:0]        lin_op_s    [SHIFTW];
  logic              lin_sign_s  [SHIFTW];
  logic              lin_valid_s [SHIFTW];

  logic [NSTG:0]      en_s;
  logic [NSTG-1:0]    stg_v_s;
  logic [WIDTH-1:0]   entry_s;
  logic [WIDTH-1:0]   exit_s;
  logic               out_v_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_zero_r;

  // Entry reversal for left shifts and exit reversal after the last level.
  always_comb begin
    entry_s = in_data;
    exit_s  = lout_data_s[SHIFTW-1];
    if (op_is_sll(in_op)) begin
      for (int i = 0; i < WIDTH; i++) entry_s[i] = in_data[WIDTH-1-i];
    end else begin
      entry_s = in_data;
    end
    if (op_is_sll(lin_op_s[SHIFTW-1])) begin
      for (int i = 0; i < WIDTH; i++) exit_s[i] = lout_data_s[SHIFTW-1][WIDTH-1-i];
    end else begin
      exit_s = lout_data_s[SHIFTW-1];
    end
  end

  // First level is always fed from the input port; the sign is captured here.
  assign lin_data_s[0]  = entry_s;
  assign lin_shamt_s[0] = in_shamt;
  assign lin_op_s[0]    = in_op;
  assign lin_sign_s[0]  = in_data[WIDTH-1];
  assign lin_valid_s[0] = in_valid;

  for (genvar k = 0; k < SHIFTW; k++) begin : g_lvl
    shift_level #(
      .WIDTH (WIDTH),
      .AMT   (2 ** k)
    ) u_level (
      .data   (lin_data_s[k]),
      .en     (lin_shamt_s[k][0]),
      .op     (lin_op_s[k]),
      .sign   (lin_sign_s[k]),
      .result (lout_data_s[k])
    );
  end

  if (REG_LVL != 0) begin : g_piped
    for (genvar k = 0; k < SHIFTW - 1; k++) begin : g_stage
      logic              v_r;
      logic [WIDTH-1:0]  data_r;
      logic [SHIFTW-1:0] shamt_r;
      logic [1:0]        op_r;
      logic              sign_r;

      // Stage register: take the level result when enabled, otherwise hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r     <= 1'b0;
          data_r  <= {WIDTH{1'b0}};
          shamt_r <= {SHIFTW{1'b0}};
          op_r    <= 2'b00;
          sign_r  <= 1'b0;
        end else if (en_s[k]) begin
          v_r     <= lin_valid_s[k];
          data_r  <= lout_data_s[k];
          shamt_r <= lin_shamt_s[k] >> 1;
          op_r    <= lin_op_s[k];
          sign_r  <= lin_sign_s[k];
        end
      end

      assign stg_v_s[k]       = v_r;
      assign lin_data_s[k+1]  = data_r;
      assign lin_shamt_s[k+1] = shamt_r;
      assign lin_op_s[k+1]    = op_r;
      assign lin_sign_s[k+1]  = sign_r;
      assign lin_valid_s[k+1] = v_r;
    end
  end else begin : g_comb
    for (genvar k = 1; k < SHIFTW; k++) begin : g_chain
      assign lin_data_s[k]  = lout_data_s[k-1];
      assign lin_shamt_s[k] = in_shamt >> k;
      assign lin_op_s[k]    = in_op;
      assign lin_sign_s[k]  = in_data[WIDTH-1];
      assign lin_valid_s[k] = in_valid;
    end
  end

  assign stg_v_s[NSTG-1] = out_v_r;

  // Enable chain from the output back to the input: a stage moves when it is
  // empty or when the stage after it moves.
  always_comb begin
    en_s       = {(NSTG+1){1'b0}};
    en_s[NSTG] = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      en_s[k] = !stg_v_s[k] || en_s[k+1];
    end
  end

  // Output stage: registered result and zero flag, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_r    <= 1'b0;
      out_data_r <= {WIDTH{1'b0}};
      out_zero_r <= 1'b1;
    end else if (en_s[NSTG-1]) begin
      out_v_r    <= lin_valid_s[SHIFTW-1];
      out_data_r <= exit_s;
      out_zero_r <= (exit_s == {WIDTH{1'b0}});
    end
  end

  assign in_ready  = en_s[0];
  assign out_valid = out_v_r;
  assign out_data  = out_data_r;
  assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32, REG_LVL=1).
// A reference model computes results with plain shift operators; a monitor
// scoreboards every retired beat and checks hold stability under stall.
module tb_pipelined_barrel_shifter;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [4:0]  in_shamt = 5'd0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_push = 0;
  int n_pop = 0;
  int n_disc = 0;
  logic [31:0] exp_q[$];
  int          retire_cyc[$];
  bit          hold_pending = 1'b0;
  logic [31:0] held_data;
  logic        held_zero;

  pipelined_barrel_shifter #(.WIDTH(32), .SHIFTW(5), .REG_LVL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    logic [63:0] dbl;
    case (op)
      2'b00:   return d >> sh;
      2'b01:   return 32'($signed(d) >>> sh);
      2'b10:   return d << sh;
      default: begin
        dbl = {d, d} >> sh;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: scoreboard retired beats, record accepted beats, check stall hold.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (hold_pending) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, held_data);
        check("stall_zero", {31'd0, out_zero}, {31'd0, held_zero});
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_zero    = out_zero;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("sb_data", out_data, e);
          check("sb_zero", {31'd0, out_zero}, {31'd0, (e == 32'h0)});
        end
        retire_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_op, in_data, in_shamt));
        n_push++;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  // Single beat with literal expectation, latency and zero flag checks.
  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [31:0] exp_v);
    int lat;
    bit seen;
    check({name, "_model"}, ref_shift(op, d, sh), exp_v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh;
    @(negedge clk);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat = i;
      end else begin
        @(posedge clk);
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check({name, "_data"}, out_data, exp_v);
    check({name, "_zero"}, {31'd0, out_zero}, {31'd0, (exp_v == 32'h0)});
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    int stale;
    bit got;
    int shv [5] = '{0, 1, 7, 16, 31};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors
    run_vec("srl3",  2'b00, 32'hFFFF0000, 5'd3,  32'h1FFFE000);
    run_vec("sra4",  2'b01, 32'h80000000, 5'd4,  32'hF8000000);
    run_vec("sra31", 2'b01, 32'h7FFFFFFF, 5'd31, 32'h00000000);
    run_vec("sra31n",2'b01, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    run_vec("sll4",  2'b10, 32'h00001111, 5'd4,  32'h00011110);
    run_vec("sll1",  2'b10, 32'h80000001, 5'd1,  32'h00000002);
    run_vec("ror4",  2'b11, 32'h0000000F, 5'd4,  32'hF0000000);
    run_vec("ror1",  2'b11, 32'h00000001, 5'd1,  32'h80000000);
    run_vec("srl31", 2'b00, 32'h80000000, 5'd31, 32'h00000001);
    for (int op = 0; op < 4; op++) begin
      run_vec($sformatf("sh0_op%0d", op), 2'(op), 32'hA5A50F0F, 5'd0, 32'hA5A50F0F);
    end
    drain("directed");

    // Streaming: 8 back-to-back beats, results on consecutive cycles
    base = retire_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 2'(i % 4); in_data = 32'h12345678 + 32'(i * 32'h01111111);
      in_shamt = 5'(i * 3 + 1);
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("stream");
    check("stream_count", 32'(retire_cyc.size() - base), 32'd8);
    if (retire_cyc.size() - base == 8) begin
      for (int i = 0; i < 7; i++) begin
        check("stream_consecutive", 32'(retire_cyc[base+i+1] - retire_cyc[base+i]), 32'd1);
      end
    end

    // Backpressure: stream continuously with out_ready low for 10 cycles
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 2'(acc % 4); in_data = 32'hC0DE0000 + 32'(acc);
      in_shamt = 5'(acc * 5 + 2);
      @(negedge clk);
      if (in_ready) acc++;
    end
    check("bp_accepted", 32'(acc), 32'(LAT));
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("bp");

    // Reset with 3 beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 2'b11; in_data = 32'h0F0F0000 + 32'(i); in_shamt = 5'(i + 8);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_zero", {31'd0, out_zero}, 32'd1);
    n_disc += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("post_rst_stale", 32'(stale), 32'd0);

    // Mixed ops and shift amounts with intermittent backpressure
    for (int v = 0; v < 20; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 2'(v % 4); in_shamt = 5'(shv[v / 4]);
      in_data = 32'h8C3AF051 + 32'(v * 32'h01010101);
      out_ready = (v % 3 != 0);
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        else begin
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
      check("mix_accept", {31'd0, got}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("mix");

    check("beats_conserved", 32'(n_push), 32'(n_pop + n_disc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
